ram32_spi_bridge: RTL and testbench



---
 rtl/ram32_spi_bridge.sv | 175 +++++++++++++++++
 tb/tb_ram32_spi_bridge.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram32_spi_bridge.sv
// ram32_spi_bridge: SPI mode-0 slave giving a host word-level access to the
// 32x32 on-chip RAM macro. The SPI pins are oversampled in the CLK domain.
// A one-byte command selects read/write and the start address. Each 32-bit
// word becomes a single-cycle RAM enable/write pulse.
// Optional feature: define RAM32_BRIDGE_BURST_EN to honour command bit6
// (burst, auto-incrementing address) until chip select rises.
module ram32_spi_bridge (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [4:0]  ram_a,
  output logic [31:0] ram_di,
  input  logic [31:0] ram_do,
  output logic        busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CMD     = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] ACCESS  = 3'd3;
  localparam logic [2:0] CAPTURE = 3'd4;

  logic        sclk_s1, sclk_s2, sclk_d;
  logic        cs_s1, cs_s2;
  logic        mosi_s1, mosi_s2;
  logic        sclk_rise, sclk_fall;

  logic [2:0]  state;
  logic [4:0]  bit_cnt;
  logic [31:0] rx_sr;
  logic [31:0] tx_sr;
  logic        is_write;
  logic        burst;
  logic        done;     // single-word transaction finished; ignore further bits

  // Two-flop synchronisers plus one delay stage on SCLK for edge detection
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the old value of
      // the one before it, which is what makes this a real two-stage chain.
      sclk_s1 <= spi_sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      cs_s1   <= spi_cs_n;
      cs_s2   <= cs_s1;
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;
  assign busy      = ~cs_s2;
  assign ram_en    = (state == ACCESS);
  assign ram_we    = (ram_en && is_write) ? 4'hF : 4'h0;

  // Transaction FSM: command decode, bit shifting and RAM access sequencing
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state    <= IDLE;
      bit_cnt  <= 5'd0;
      rx_sr    <= 32'd0;
      tx_sr    <= 32'd0;
      is_write <= 1'b0;
      burst    <= 1'b0;
      done     <= 1'b0;
      spi_miso <= 1'b0;
      ram_a    <= 5'd0;
      ram_di   <= 32'd0;
    end else if (cs_s2 && (state != IDLE)) begin
      // Deselect aborts; an ACCESS in progress has already driven its pulse.
      state    <= IDLE;
      spi_miso <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          spi_miso <= 1'b0;
          if (!cs_s2) begin
            state   <= CMD;
            bit_cnt <= 5'd0;
            rx_sr   <= 32'd0;
            done    <= 1'b0;
          end
        end

        CMD: begin
          spi_miso <= 1'b0;
          if (sclk_rise) begin
            rx_sr   <= {rx_sr[30:0], mosi_s2};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              // The command byte is rx_sr[6:0] plus the bit arriving now,
              // so bit7 sits in rx_sr[6], bit6 in rx_sr[5], bit5 is dropped.
              ram_a    <= {rx_sr[3:0], mosi_s2};
              is_write <= rx_sr[6];
`ifdef RAM32_BRIDGE_BURST_EN
              burst    <= rx_sr[5];
`else
              burst    <= 1'b0;
`endif
              bit_cnt  <= 5'd0;
              state    <= rx_sr[6] ? DATA : ACCESS;
            end
          end
        end

        DATA: begin
          if (is_write) begin
            spi_miso <= 1'b0;
            if (sclk_rise && !done) begin
              rx_sr   <= {rx_sr[30:0], mosi_s2};
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd31) begin
                ram_di <= {rx_sr[30:0], mosi_s2};
                state  <= ACCESS;
              end
            end
          end else if (sclk_fall) begin
            if (done) begin
              spi_miso <= 1'b0;
            end else begin
              spi_miso <= tx_sr[31];
              tx_sr    <= {tx_sr[30:0], 1'b0};
              bit_cnt  <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd31) begin
                if (burst) begin
                  // Prefetch the next word right after bit0 goes out.
                  ram_a <= ram_a + 5'd1;
                  state <= ACCESS;
                end else begin
                  done <= 1'b1;
                end
              end
            end
          end
        end

        ACCESS: begin
          if (is_write) begin
            bit_cnt <= 5'd0;
            state   <= DATA;
            if (burst) ram_a <= ram_a + 5'd1;
            else       done  <= 1'b1;
          end else begin
            state <= CAPTURE;
          end
        end

        CAPTURE: begin
          // RAM output is valid the cycle after the enable pulse.
          tx_sr   <= ram_do;
          bit_cnt <= 5'd0;
          state   <= DATA;
        end

        // NOTE: unreachable encodings recover to IDLE instead of locking up.
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram32_spi_bridge.sv
// tb_ram32_spi_bridge: drives the bridge as an SPI host against a behavioural
// 32x32 RAM. Expected RAM accesses are queued as stimulus is sent and compared
// when the bridge pulses ram_en; read words are compared against the vectors.
// Expectations follow RAM32_BRIDGE_BURST_EN when it is defined.
module tb_ram32_spi_bridge;

  localparam int HALF = 10;  // SCLK half period in CLK cycles

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        spi_sclk, spi_cs_n, spi_mosi;
  logic        spi_miso;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [4:0]  ram_a;
  logic [31:0] ram_di;
  logic [31:0] ram_do;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  a;
    logic [3:0]  we;
    logic [31:0] d;
  } acc_t;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  acc_t        exp_q[$];
  logic [31:0] mem[32];
  logic        tb_init;
  logic        prev_en;

  ram32_spi_bridge dut (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .spi_sclk (spi_sclk),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_a    (ram_a),
    .ram_di   (ram_di),
    .ram_do   (ram_do),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  // Behavioural RAM macro: byte-lane writes, registered read, 0 when idle
  always @(posedge CLK) begin
    if (tb_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA5A50000 | i;
      ram_do <= 32'd0;
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
      ram_do <= mem[ram_a];
    end else begin
      ram_do <= 32'd0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every ram_en pulse must match the oldest queued expectation
  always @(negedge CLK) begin
    if (ram_en === 1'b1) begin
      check("ram_en_width", {31'd0, prev_en === 1'b1}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_access actual=a%0d/we%h expected=none", ram_a, ram_we);
      end else begin
        acc_t e;
        e = exp_q.pop_front();
        check("ram_a", {27'd0, ram_a}, {27'd0, e.a});
        check("ram_we", {28'd0, ram_we}, {28'd0, e.we});
        if (e.we != 4'h0) check("ram_di", ram_di, e.d);
      end
    end
    prev_en = ram_en;
  end

  task automatic spi_begin();
    spi_cs_n = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  task automatic spi_end();
    repeat (6) @(negedge CLK);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge CLK);
  endtask

  task automatic spi_bit(input logic mo, output logic mi);
    spi_mosi = mo;
    repeat (HALF) @(negedge CLK);
    mi = spi_miso;
    spi_sclk = 1'b1;
    repeat (HALF) @(negedge CLK);
    spi_sclk = 1'b0;
  endtask

  // Full transaction: command byte then nd data bits; rd collects MISO
  task automatic spi_xfer(input logic [7:0] cmd, input logic [63:0] wd,
                          input int nd, output logic [63:0] rd);
    logic mi;
    rd = 64'd0;
    spi_begin();
    for (int i = 7; i >= 0; i--) spi_bit(cmd[i], mi);
    for (int i = 0; i < nd; i++) begin
      spi_bit(wd[63-i], mi);
      rd = {rd[62:0], mi};
    end
    spi_end();
  endtask

  task automatic push(input logic [4:0] a, input logic [3:0] we, input logic [31:0] d);
    acc_t e;
    e.a = a; e.we = we; e.d = d;
    exp_q.push_back(e);
  endtask

  vec_t        vecs[9];
  logic [63:0] rd;
  logic        mi;
  int          bad;

  initial begin
    vecs[0] = '{8'h85, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{8'h05, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{8'h80, 32'h12345678, 32'h0};
    vecs[3] = '{8'h9F, 32'hCAFEF00D, 32'h0};
    vecs[4] = '{8'h1F, 32'h0,        32'hCAFEF00D};
    vecs[5] = '{8'h00, 32'h0,        32'h12345678};
    vecs[6] = '{8'h25, 32'h0,        32'hDEADBEEF};
    vecs[7] = '{8'hA5, 32'h0F0F0F0F, 32'h0};
    vecs[8] = '{8'h05, 32'h0,        32'h0F0F0F0F};

    // Reset held with inputs toggling: outputs must stay at reset values
    RESETn = 1'b0; tb_init = 1'b1; prev_en = 1'b0;
    spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    bad = 0;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 40; i++) begin
      spi_sclk = 1'($urandom); spi_cs_n = 1'($urandom); spi_mosi = 1'($urandom);
      @(negedge CLK);
      if (spi_miso !== 1'b0 || ram_en !== 1'b0 || ram_we !== 4'h0 ||
          ram_a !== 5'd0 || ram_di !== 32'd0 || busy !== 1'b0) bad++;
    end
    check("reset_hold_outputs", bad, 0);
    spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    tb_init = 1'b0;
    @(negedge CLK);
    RESETn = 1'b1;
    repeat (5) @(negedge CLK);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_miso", {31'd0, spi_miso}, 32'd0);

    // Busy follows the synchronised chip select
    spi_cs_n = 1'b0;
    repeat (4) @(negedge CLK);
    check("busy_selected", {31'd0, busy}, 32'd1);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge CLK);

    // Table-driven single-word transactions
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].cmd[7]) begin
        push(vecs[i].cmd[4:0], 4'hF, vecs[i].wdata);
        spi_xfer(vecs[i].cmd, {vecs[i].wdata, 32'h0}, 32, rd);
      end else begin
        push(vecs[i].cmd[4:0], 4'h0, 32'h0);
        spi_xfer(vecs[i].cmd, 64'h0, 32, rd);
        check($sformatf("read_vec%0d", i), rd[31:0], vecs[i].exp_rd);
      end
    end

    // Write to address 3 aborted after 20 data bits: no RAM write
    spi_xfer(8'h83, 64'hFFFFFFFF_FFFFFFFF, 20, rd);
    push(5'd3, 4'h0, 32'h0);
    spi_xfer(8'h03, 64'h0, 32, rd);
    check("partial_write_read3", rd[31:0], 32'hA5A50003);

    // Two-word write starting at 31, then two-word read
    push(5'd31, 4'hF, 32'h11111111);
`ifdef RAM32_BRIDGE_BURST_EN
    push(5'd0, 4'hF, 32'h22222222);
`endif
    spi_xfer(8'hDF, 64'h11111111_22222222, 64, rd);
    push(5'd31, 4'h0, 32'h0);
`ifdef RAM32_BRIDGE_BURST_EN
    push(5'd0, 4'h0, 32'h0);
    push(5'd1, 4'h0, 32'h0);  // prefetch after the second word's bit0
`endif
    spi_xfer(8'h5F, 64'h0, 64, rd);
    check("burst_read_word0", rd[63:32], 32'h11111111);
`ifdef RAM32_BRIDGE_BURST_EN
    check("burst_read_word1", rd[31:0], 32'h22222222);
`else
    check("single_read_word1", rd[31:0], 32'h00000000);
`endif
    push(5'd0, 4'h0, 32'h0);
    spi_xfer(8'h00, 64'h0, 32, rd);
`ifdef RAM32_BRIDGE_BURST_EN
    check("read_addr0_after_burst", rd[31:0], 32'h22222222);
`else
    check("read_addr0_unchanged", rd[31:0], 32'h12345678);
`endif

    // Reset pulsed 2 CLK after the 16th data bit of a write to address 4
    spi_begin();
    for (int i = 7; i >= 0; i--) spi_bit(bit'(8'h84 >> i), mi);
    for (int i = 0; i < 16; i++) spi_bit(1'b1, mi);
    repeat (2) @(negedge CLK);
    RESETn = 1'b0;
    spi_cs_n = 1'b1;
    repeat (3) @(negedge CLK);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_ram_en", {31'd0, ram_en}, 32'd0);
    check("midreset_ram_di", ram_di, 32'd0);
    RESETn = 1'b1;
    repeat (6) @(negedge CLK);
    push(5'd4, 4'h0, 32'h0);
    spi_xfer(8'h04, 64'h0, 32, rd);
    check("read4_after_reset", rd[31:0], 32'hA5A50004);
    push(5'd4, 4'hF, 32'h55AA55AA);
    spi_xfer(8'h84, 64'h55AA55AA_00000000, 32, rd);
    push(5'd4, 4'h0, 32'h0);
    spi_xfer(8'h04, 64'h0, 32, rd);
    check("read4_after_write", rd[31:0], 32'h55AA55AA);

    repeat (10) @(negedge CLK);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
